// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction-fetch unit.
// Holds the cache <-> refill payload structs, the refill FSM state enum
// and the line geometry constants used by i_mem_refill_ctrl.
package ifu_pkg;

   localparam int unsigned WORD_W        = 32;
   localparam int unsigned LINE_WORDS    = 4;
   localparam int unsigned LINE_W        = WORD_W * LINE_WORDS;
   localparam int unsigned LINE_OFFSET_W = 4;
   localparam int unsigned CNT_W         = 3;

   typedef struct packed {
      logic        valid;
      logic [31:0] address;
   } t_cache2i_mem_req;

   typedef struct packed {
      logic         valid;
      logic [31:0]  address;
      logic [127:0] filled_instruction;
   } t_i_mem2cache_rsp;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FETCH   = 2'd1,
      RESPOND = 2'd2
   } t_refill_state;

endpackage

// File: rtl/i_mem_refill_ctrl.sv
// Instruction-cache line refill controller.
// Takes one miss request, issues four word reads to instruction memory
// (ready/valid, bounded outstanding count), assembles the returned words
// into a 128-bit line and returns it to the cache as a one-cycle response.
// Ports:
//   clk, rst             clock, async active-high reset
//   cache2i_mem_req      miss request (valid, address)
//   i_mem2cache_rsp      registered refill response (valid, address, line)
//   mem_rd_req_valid     registered word read request valid
//   mem_rd_req_ready     memory accepts the request this cycle
//   mem_rd_addr          registered word-aligned read address
//   mem_rd_rsp_valid     in-order read data valid
//   mem_rd_rsp_data      read data
//   refill_busy          registered, high whenever not IDLE
module i_mem_refill_ctrl
   import ifu_pkg::*;
#(
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  t_cache2i_mem_req cache2i_mem_req,
   output t_i_mem2cache_rsp i_mem2cache_rsp,
   output logic             mem_rd_req_valid,
   input  logic             mem_rd_req_ready,
   output logic [31:0]      mem_rd_addr,
   input  logic             mem_rd_rsp_valid,
   input  logic [31:0]      mem_rd_rsp_data,
   output logic             refill_busy
);

   t_refill_state    r_state,     w_state_nxt;
   logic [31:0]      r_req_addr,  w_req_addr_nxt;
   logic [31:0]      r_line_base, w_line_base_nxt;
   logic [CNT_W-1:0] r_issue_cnt, w_issue_cnt_nxt;
   logic [CNT_W-1:0] r_rcv_cnt,   w_rcv_cnt_nxt;
   logic [LINE_W-1:0] r_line,     w_line_nxt;
   logic             r_rd_valid,  w_rd_valid_nxt;
   logic [31:0]      r_rd_addr,   w_rd_addr_nxt;
   t_i_mem2cache_rsp r_rsp,       w_rsp_nxt;
   logic             r_busy,      w_busy_nxt;

   logic             w_issue_fire;
   logic             w_rcv_fire;
   logic [CNT_W-1:0] w_out_nxt;
   logic [6:0]       w_wr_lsb;

   assign w_issue_fire = r_rd_valid & mem_rd_req_ready;
   // Guard keeps a stray extra response from wrapping into word 0.
   assign w_rcv_fire   = mem_rd_rsp_valid & (r_rcv_cnt < CNT_W'(LINE_WORDS));
   assign w_wr_lsb     = {r_rcv_cnt[1:0], 5'd0};

   // Next-state, counters, line assembly and next output values.
   always_comb begin
      w_state_nxt     = r_state;
      w_req_addr_nxt  = r_req_addr;
      w_line_base_nxt = r_line_base;
      w_issue_cnt_nxt = r_issue_cnt;
      w_rcv_cnt_nxt   = r_rcv_cnt;
      w_line_nxt      = r_line;
      w_rd_valid_nxt  = 1'b0;
      w_rd_addr_nxt   = r_rd_addr;
      w_rsp_nxt       = r_rsp;
      w_rsp_nxt.valid = 1'b0;
      w_out_nxt       = '0;

      case (r_state)
         IDLE: begin
            if (cache2i_mem_req.valid) begin
               w_state_nxt     = FETCH;
               w_req_addr_nxt  = cache2i_mem_req.address;
               w_line_base_nxt = {cache2i_mem_req.address[31:LINE_OFFSET_W],
                                  LINE_OFFSET_W'(0)};
               w_issue_cnt_nxt = '0;
               w_rcv_cnt_nxt   = '0;
               w_line_nxt      = '0;
               // First read goes out next cycle straight from registers.
               w_rd_valid_nxt  = 1'b1;
               w_rd_addr_nxt   = {cache2i_mem_req.address[31:LINE_OFFSET_W],
                                  LINE_OFFSET_W'(0)};
            end
         end

         FETCH: begin
            w_issue_cnt_nxt = r_issue_cnt + CNT_W'(w_issue_fire);
            w_rcv_cnt_nxt   = r_rcv_cnt + CNT_W'(w_rcv_fire);
            if (w_rcv_fire) begin
               w_line_nxt[w_wr_lsb +: WORD_W] = mem_rd_rsp_data;
            end
            w_out_nxt = w_issue_cnt_nxt - w_rcv_cnt_nxt;

            if (w_rcv_cnt_nxt == CNT_W'(LINE_WORDS)) begin
               w_state_nxt                  = RESPOND;
               w_rsp_nxt.valid              = 1'b1;
               w_rsp_nxt.address            = r_req_addr;
               w_rsp_nxt.filled_instruction = w_line_nxt;
            end else begin
               // Valid held while unaccepted: issue count and address do not
               // move, and outstanding can only shrink.
               w_rd_valid_nxt = (w_issue_cnt_nxt < CNT_W'(LINE_WORDS)) &&
                                (32'(w_out_nxt) < MAX_OUTSTANDING);
               w_rd_addr_nxt  = r_line_base + 32'({w_issue_cnt_nxt, 2'b00});
            end
         end

         RESPOND: begin
            w_state_nxt = IDLE;
         end

         default: begin
            w_state_nxt = IDLE;
         end
      endcase

      w_busy_nxt = (w_state_nxt != IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_req_addr  <= '0;
         r_line_base <= '0;
         r_issue_cnt <= '0;
         r_rcv_cnt   <= '0;
         r_line      <= '0;
         r_rd_valid  <= 1'b0;
         r_rd_addr   <= '0;
         r_rsp       <= '0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_req_addr  <= w_req_addr_nxt;
         r_line_base <= w_line_base_nxt;
         r_issue_cnt <= w_issue_cnt_nxt;
         r_rcv_cnt   <= w_rcv_cnt_nxt;
         r_line      <= w_line_nxt;
         r_rd_valid  <= w_rd_valid_nxt;
         r_rd_addr   <= w_rd_addr_nxt;
         r_rsp       <= w_rsp_nxt;
         r_busy      <= w_busy_nxt;
      end
   end

   assign i_mem2cache_rsp  = r_rsp;
   assign mem_rd_req_valid = r_rd_valid;
   assign mem_rd_addr      = r_rd_addr;
   assign refill_busy      = r_busy;

endmodule
